// File: rtl/regbus_ctrl_if.sv
// regbus_ctrl_if: control bundle between the instruction source/datapath and regbus_ctrl
// RUN/IR_IN in (start strobe, instruction word); SEL/RIN/WSRC/AIN/GIN/ADDSUB out (bus mux, reg enables, ALU control); BUSY/DONE out (status)
interface regbus_ctrl_if #(parameter int IW = 9, parameter int NREG = 7);
  logic            RUN;
  logic [IW-1:0]   IR_IN;
  logic [2:0]      SEL;
  logic [NREG-1:0] RIN;
  logic            WSRC;
  logic            AIN;
  logic            GIN;
  logic            ADDSUB;
  logic            BUSY;
  logic            DONE;
  modport master (output RUN, IR_IN, input SEL, RIN, WSRC, AIN, GIN, ADDSUB, BUSY, DONE);
  modport slave (input RUN, IR_IN, output SEL, RIN, WSRC, AIN, GIN, ADDSUB, BUSY, DONE);
endinterface

// File: rtl/regbus_ctrl.sv
// regbus_ctrl: FSM sequencing bus select, register enables and ALU latches for mv/mvi/add/sub
// CLK/RST: clock and sync active-high reset; bus: regbus_ctrl_if slave (RUN, IR_IN in; SEL, RIN, WSRC, AIN, GIN, ADDSUB, BUSY, DONE out)
module regbus_ctrl #(
  parameter int IW = 9,
  parameter int NREG = 7
) (
  input logic         CLK,
  input logic         RST,
  regbus_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [2:0] op, x, y;
  logic [NREG:0] oh;
  logic [NREG-1:0] rin;
  logic ain, gin, done;
  assign op = ir_q[8:6];
  assign x = ir_q[5:3];
  assign y = ir_q[2:0];
  // bit 0 of the shifted vector stands for R0 and is dropped, so X = 0 writes nothing
  assign oh = {{NREG{1'b0}}, 1'b1} << x;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ir_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
    end
  end
  always_comb begin
    state_d = IDLE;
    ir_d = ir_q;
    bus.SEL = 3'd0;
    rin = '0;
    bus.WSRC = 1'b0;
    ain = 1'b0;
    gin = 1'b0;
    bus.ADDSUB = 1'b0;
    done = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = bus.RUN ? T1 : IDLE;
        ir_d = bus.RUN ? bus.IR_IN : ir_q;
      end
      T1: begin
        if (op[2:1] == 2'b01) begin
          bus.SEL = x;
          ain = 1'b1;
          state_d = T2;
        end else begin
          // mv reads Ry, mvi reads the immediate on DIN (select 0)
          bus.SEL = (op == 3'b000) ? y : 3'd0;
          rin = op[2] ? '0 : oh[NREG:1];
          done = 1'b1;
        end
      end
      T2: begin
        bus.SEL = y;
        gin = 1'b1;
        bus.ADDSUB = ir_q[6];
        state_d = T3;
      end
      T3: begin
        bus.WSRC = 1'b1;
        rin = oh[NREG:1];
        done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // reset masks every write-side strobe so an aborted instruction leaves no partial update
  assign bus.RIN = RST ? '0 : rin;
  assign bus.AIN = ain & ~RST;
  assign bus.GIN = gin & ~RST;
  assign bus.DONE = done & ~RST;
  assign bus.BUSY = state_q != IDLE;
endmodule

// File: tb/tb_regbus_ctrl.sv
// tb_regbus_ctrl: scoreboard bench driving regbus_ctrl through a behavioural regfile/ALU datapath
module tb_regbus_ctrl;
  typedef logic [7:0][15:0] rf_t;
  typedef struct {
    rf_t r;
    int  dc;
  } exp_t;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [15:0] din = '0;
  rf_t dp = '0;
  rf_t m = '0;
  logic [15:0] a_q, g_q, busv;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int last_done = 0;
  int c0;
  exp_t q[$];
  exp_t pend;
  bit pending = 1'b0;
  regbus_ctrl_if bus ();
  regbus_ctrl dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  assign bus.IR_IN = din[8:0];
  assign busv = (bus.SEL == 3'd0) ? din : dp[bus.SEL];
  always @(posedge CLK) begin
    if (bus.AIN) a_q <= busv;
    if (bus.GIN) g_q <= bus.ADDSUB ? a_q - busv : a_q + busv;
    for (int k = 1; k < 8; k++) if (bus.RIN[k-1]) dp[k] <= bus.WSRC ? g_q : busv;
  end
  task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask
  task automatic co(input string nm, input logic [2:0] s, input logic [6:0] r, input logic [5:0] f);
    ck(nm, {16'h0, bus.SEL, bus.RIN, bus.WSRC, bus.AIN, bus.GIN, bus.ADDSUB, bus.BUSY, bus.DONE}, {16'h0, s, r, f});
  endtask
  task automatic issue(input logic [8:0] ins, input logic [15:0] d);
    int n = 0;
    int lat = 1;
    logic [2:0] op, x, y;
    logic [15:0] s, a;
    exp_t e;
    while (bus.BUSY && n < 10) begin
      bus.RUN = 1'($urandom);
      @(negedge CLK);
      n++;
    end
    if (bus.BUSY) begin
      checks++;
      errors++;
      $display("FAIL issue_wait: busy=%0b expected 0", bus.BUSY);
    end
    op = ins[8:6];
    x = ins[5:3];
    y = ins[2:0];
    s = (y == 0) ? d : m[y];
    a = (x == 0) ? d : m[x];
    if (op == 3'd0 && x != 0) m[x] = s;
    if (op == 3'd1 && x != 0) m[x] = d;
    if (op == 3'd2 || op == 3'd3) begin
      lat = 3;
      if (x != 0) m[x] = (op == 3'd3) ? a - s : a + s;
    end
    e.r = m;
    e.dc = cyc + lat;
    q.push_back(e);
    bus.RUN = 1'b1;
    din = {7'($urandom), ins};
    @(negedge CLK);
    bus.RUN = 1'b0;
    din = d;
  endtask
  always @(negedge CLK) begin
    if (pending) begin
      for (int k = 1; k < 8; k++) ck($sformatf("reg_r%0d", k), {16'h0, dp[k]}, {16'h0, pend.r[k]});
      pending = 1'b0;
    end
    if (!RST) begin
      ck("exclusive_enables", {29'h0, $countones(bus.RIN) <= 1, !((bus.AIN || bus.GIN) && bus.RIN != 0), !(bus.AIN && bus.GIN)}, 32'h7);
      if (bus.DONE) begin
        last_done = cyc;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: DONE=1 at cycle %0d with nothing outstanding", cyc);
        end else begin
          pend = q.pop_front();
          pending = 1'b1;
          ck("done_cycle", cyc, pend.dc);
        end
      end else if (q.size() != 0 && cyc > q[0].dc) begin
        checks++;
        errors++;
        $display("FAIL done_missing: cycle %0d expected DONE at %0d", cyc, q[0].dc);
        void'(q.pop_front());
      end
    end
  end
  initial begin
    bus.RUN = 1'b0;
    repeat (2) @(negedge CLK);
    co("reset", 3'd0, 7'd0, 6'b000000);
    RST = 1'b0;
    @(negedge CLK);
    co("idle", 3'd0, 7'd0, 6'b000000);
    issue(9'b000_011_101, 16'($urandom));
    co("mv_t1", 3'd5, 7'b0000100, 6'b000011);
    @(negedge CLK);
    co("mv_after", 3'd0, 7'd0, 6'b000000);
    issue(9'b001_000_000, 16'($urandom));
    co("mvi_r0", 3'd0, 7'd0, 6'b000011);
    issue(9'b001_111_000, 16'($urandom));
    co("mvi_r7", 3'd0, 7'b1000000, 6'b000011);
    issue(9'b001_010_000, 16'h0005);
    issue(9'b001_110_000, 16'h0003);
    issue(9'b010_010_110, 16'($urandom));
    co("add_t1", 3'd2, 7'd0, 6'b010010);
    @(negedge CLK);
    co("add_t2", 3'd6, 7'd0, 6'b001010);
    @(negedge CLK);
    co("add_t3", 3'd0, 7'b0000010, 6'b100011);
    @(negedge CLK);
    ck("add_r2", {16'h0, dp[2]}, 32'h8);
    issue(9'b110_011_011, 16'($urandom));
    co("nop_t1", 3'd0, 7'd0, 6'b000011);
    @(negedge CLK);
    c0 = cyc;
    issue(9'b000_001_010, 16'($urandom));
    issue(9'b010_011_001, 16'($urandom));
    issue(9'b000_100_011, 16'($urandom));
    @(negedge CLK);
    ck("b2b_last_done", last_done - c0, 7);
    bus.RUN = 1'b1;
    din = {7'h0, 9'b011_001_000};
    @(negedge CLK);
    din = 16'h1234;
    co("sub_t1", 3'd1, 7'd0, 6'b010010);
    @(negedge CLK);
    co("sub_t2", 3'd0, 7'd0, 6'b001110);
    RST = 1'b1;
    #1 co("sub_t2_rst", 3'd0, 7'd0, 6'b000110);
    @(negedge CLK);
    co("rst_idle", 3'd0, 7'd0, 6'b000000);
    @(negedge CLK);
    RST = 1'b0;
    bus.RUN = 1'b0;
    co("rst_release", 3'd0, 7'd0, 6'b000000);
    repeat (300) begin
      repeat ($urandom_range(0, 2)) begin
        bus.RUN = 1'b0;
        @(negedge CLK);
      end
      issue({3'($urandom), 3'($urandom), 3'($urandom)}, 16'($urandom));
    end
    for (int n = 0; n < 10 && (q.size() != 0 || pending); n++) @(negedge CLK);
    ck("drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regbus_ctrl.md
Name: regbus_ctrl

Overview:
- Control FSM that sequences the register-file bus multiplexer and the register load enables for a 9-bit instruction set.
- Each cycle it drives the bus select: 0 selects DIN, 1..7 select R1..R7.
- It asserts per-register write enables, ALU operand/result latches and a write-source select, so that mv, mvi, add and sub execute over a shared 16-bit bus.
- It sits between the instruction source (DIN) and the regfile/bus mux/ALU datapath.

Parameters:
- IW, 9, instruction width; format III XXX YYY (opcode, destination, source).
- NREG, 7, number of writable registers R1..NREG; index 0 is never a destination.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- RUN  input  1  start strobe; sampled only in IDLE.
- IR_IN  input  9  instruction word (DIN[8:0]); latched when RUN is accepted.
- SEL  output  3  bus mux select; 0 = DIN, n = Rn.
- RIN  output  7  one-hot register write enables; bit k-1 enables Rk.
- WSRC  output  1  register write-data source; 0 = OUTBUS, 1 = ALU result G.
- AIN  output  1  load ALU operand register A from OUTBUS.
- GIN  output  1  load ALU result register G.
- ADDSUB  output  1  ALU op; 0 = add, 1 = sub; valid while GIN = 1.
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  single-cycle pulse in the final cycle of an instruction.

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous and active-high.
  - On a rising edge with RST = 1: state <= IDLE, IR <= 0.
  - While RST = 1, RIN, AIN, GIN and DONE are forced to 0 combinationally. This applies at reset and mid-instruction; no partial write occurs.
- Outputs are decoded combinationally from state and the latched IR. In IDLE: SEL = 0, RIN = 0, WSRC = 0, AIN = 0, GIN = 0, ADDSUB = 0, BUSY = 0, DONE = 0.
- Opcodes: 000 mv Rx,Ry; 001 mvi Rx,#D; 010 add Rx,Ry (Rx <= Rx+Ry); 011 sub (Rx <= Rx-Ry); 100-111 nop.
- States:
  - IDLE: if RUN = 1, IR <= IR_IN and go to T1; otherwise stay.
  - T1, by opcode:
    - mv: SEL = Y, RIN = onehot(X), DONE = 1, go to IDLE.
    - mvi: SEL = 0 (immediate D must be on DIN this cycle), RIN = onehot(X), DONE = 1, go to IDLE.
    - add/sub: SEL = X, AIN = 1, go to T2.
    - nop: DONE = 1, go to IDLE.
  - T2 (add/sub only): SEL = Y, GIN = 1, ADDSUB = IR[6], go to T3.
  - T3: WSRC = 1, RIN = onehot(X), SEL = 0, DONE = 1, go to IDLE.
- Latency from RUN accepted to DONE: mv/mvi/nop 1 cycle (DONE in T1); add/sub 3 cycles (DONE in T3).
- Back-to-back issue: RUN sampled in the cycle after DONE (IDLE) starts the next instruction. No overlap.
- RUN outside IDLE is ignored; IR is held stable for the whole instruction.
- X = 0 as destination: RIN = 0 in the write cycle and timing is unchanged. DONE still pulses; the instruction behaves as a write-discard.
- Y = 0 as source: SEL = 0, so DIN is read. "add Rx,R0" adds DIN.
- X = 0 in add/sub T1: SEL = 0, so A loads DIN.
- At most one RIN bit is high in any cycle. AIN, GIN and any RIN bit are never high in the same cycle.
- Illegal/unused state encodings recover to IDLE on the next edge with all enables 0.

Test Plan:
- Reset: assert RST for 2 cycles from an arbitrary state -> SEL = 0, RIN = 0, AIN = GIN = DONE = BUSY = 0; next RUN is accepted normally.
- mv: IR_IN = 000_011_101, RUN = 1 for 1 cycle -> next cycle SEL = 5, RIN = 7'b0000100, DONE = 1; following cycle BUSY = 0.
- mvi with destination R0: IR_IN = 001_000_000 -> T1 SEL = 0, RIN = 0, DONE = 1. Then IR_IN = 001_111_000 -> RIN = 7'b1000000, SEL = 0.
- add: IR_IN = 010_010_110 ->
  - T1: SEL = 2, AIN = 1.
  - T2: SEL = 6, GIN = 1, ADDSUB = 0.
  - T3: WSRC = 1, RIN = 7'b0000010, DONE = 1.
  - With a datapath model R2 = 0x0005, R6 = 0x0003, R2 ends at 0x0008.
- sub with RUN held high plus mid-op reset: IR_IN = 011_001_000 with RUN held high -> T2 ADDSUB = 1 and SEL = 0. RUN pulses during T1/T2 are ignored and a new instruction starts only after DONE. Asserting RST in T2 -> no RIN pulse and no DONE; state is IDLE after the edge.
- nop/unused opcode: IR_IN = 110_011_011 -> DONE = 1 in T1 with all enables 0. Back-to-back mv, add, mv with RUN asserted in each IDLE cycle -> DONE pulses at cycles 1, 5 and 7 after the first RUN.
